// File: rtl/run_dump_ctrl_if.sv
// Bundles the run/dump controller's core-control, register/memory read and
// dump-stream signals; master is the controller side, slave the environment.
interface run_dump_ctrl_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 16,
  parameter int REG_COUNT  = 8
);
  localparam int REG_AW = (REG_COUNT > 1) ? $clog2(REG_COUNT) : 1;

  logic                  start;
  logic                  halt_req;
  logic                  core_reset;
  logic                  core_run;
  logic [REG_AW-1:0]     reg_rd_addr;
  logic [DATA_WIDTH-1:0] reg_rd_data;
  logic [ADDR_WIDTH-1:0] mem_rd_addr;
  logic [DATA_WIDTH-1:0] mem_rd_data;
  logic                  dump_valid;
  logic                  dump_ready;
  logic [DATA_WIDTH-1:0] dump_data;
  logic                  dump_is_mem;
  logic                  dump_last;
  logic [31:0]           cycle_count;
  logic                  done;
  logic                  halted_early;

  modport master (
    input  start, halt_req, reg_rd_data, mem_rd_data, dump_ready,
    output core_reset, core_run, reg_rd_addr, mem_rd_addr, dump_valid,
           dump_data, dump_is_mem, dump_last, cycle_count, done, halted_early
  );

  modport slave (
    output start, halt_req, reg_rd_data, mem_rd_data, dump_ready,
    input  core_reset, core_run, reg_rd_addr, mem_rd_addr, dump_valid,
           dump_data, dump_is_mem, dump_last, cycle_count, done, halted_early
  );
endinterface

// File: rtl/run_dump_ctrl.sv
// Run controller: holds the core in reset, lets it run for a bounded number of
// cycles (or until it halts), then streams register and memory contents out.
module run_dump_ctrl #(
  parameter int DATA_WIDTH     = 16,
  parameter int ADDR_WIDTH     = 16,
  parameter int REG_COUNT      = 8,
  parameter int MEM_DUMP_COUNT = 10,
  parameter int RESET_CYCLES   = 2,
  parameter int RUN_CYCLES     = 50,
  parameter bit AUTO_START     = 1'b0
) (
  input logic             clk,
  input logic             reset,
  run_dump_ctrl_if.master bus
);

  localparam int REG_AW    = (REG_COUNT > 1) ? $clog2(REG_COUNT) : 1;
  localparam int MAX_WORDS = (REG_COUNT > MEM_DUMP_COUNT) ? REG_COUNT : MEM_DUMP_COUNT;
  localparam int IDX_W     = $clog2(MAX_WORDS + 1);
  localparam int HOLD_W    = $clog2(RESET_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE, RESET_HOLD, RUN, DUMP_REG, DUMP_MEM, DONE
  } state_t;

  state_t            state_q, state_d;
  logic [HOLD_W-1:0] holdCnt_q, holdCnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [31:0]       cycleCount_q, cycleCount_d;
  logic              haltedEarly_q, haltedEarly_d;
  logic              dumping, accept, regLast, memLast, launch;

  assign dumping = (state_q == DUMP_REG) || (state_q == DUMP_MEM);
  assign accept  = dumping && bus.dump_ready;
  assign regLast = (idx_q == IDX_W'(REG_COUNT - 1));
  assign memLast = (idx_q == IDX_W'(MEM_DUMP_COUNT - 1));
  assign launch  = ((state_q == IDLE) && (bus.start || AUTO_START)) ||
                   ((state_q == DONE) && bus.start);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      holdCnt_q     <= '0;
      idx_q         <= '0;
      cycleCount_q  <= '0;
      haltedEarly_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      holdCnt_q     <= holdCnt_d;
      idx_q         <= idx_d;
      cycleCount_q  <= cycleCount_d;
      haltedEarly_q <= haltedEarly_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    holdCnt_d     = holdCnt_q;
    idx_d         = idx_q;
    cycleCount_d  = cycleCount_q;
    haltedEarly_d = haltedEarly_q;
    case (state_q)
      RESET_HOLD: begin
        if (holdCnt_q == HOLD_W'(RESET_CYCLES - 1)) state_d = RUN;
        else                                        holdCnt_d = holdCnt_q + 1'b1;
      end
      RUN: begin
        // A halt on the final budgeted cycle still counts as an early halt.
        cycleCount_d = cycleCount_q + 32'd1;
        if (bus.halt_req) begin
          haltedEarly_d = 1'b1;
          state_d       = DUMP_REG;
          idx_d         = '0;
        end else if (cycleCount_q == 32'(RUN_CYCLES - 1)) begin
          state_d = DUMP_REG;
          idx_d   = '0;
        end
      end
      DUMP_REG: begin
        if (accept) begin
          if (regLast) begin
            idx_d   = '0;
            state_d = (MEM_DUMP_COUNT == 0) ? DONE : DUMP_MEM;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      DUMP_MEM: begin
        if (accept) begin
          if (memLast) state_d = DONE;
          else         idx_d   = idx_q + 1'b1;
        end
      end
      IDLE, DONE: ;
      default: state_d = IDLE;
    endcase
    if (launch) begin
      state_d       = RESET_HOLD;
      holdCnt_d     = '0;
      idx_d         = '0;
      cycleCount_d  = '0;
      haltedEarly_d = 1'b0;
    end
  end

  always_comb begin
    bus.core_reset   = (state_q == IDLE) || (state_q == RESET_HOLD);
    bus.core_run     = (state_q == RUN);
    bus.done         = (state_q == DONE);
    bus.cycle_count  = cycleCount_q;
    bus.halted_early = haltedEarly_q;
    bus.dump_valid   = dumping;
    bus.dump_data    = {DATA_WIDTH{1'b0}};
    bus.dump_is_mem  = 1'b0;
    bus.dump_last    = 1'b0;
    bus.reg_rd_addr  = '0;
    bus.mem_rd_addr  = '0;
    case (state_q)
      DUMP_REG: begin
        bus.reg_rd_addr = REG_AW'(idx_q);
        bus.dump_data   = bus.reg_rd_data;
        bus.dump_last   = (MEM_DUMP_COUNT == 0) && regLast;
      end
      DUMP_MEM: begin
        bus.mem_rd_addr = ADDR_WIDTH'(idx_q);
        bus.dump_data   = bus.mem_rd_data;
        bus.dump_is_mem = 1'b1;
        bus.dump_last   = memLast;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_run_dump_ctrl.sv
// Bench for run_dump_ctrl: three instances (default, no memory dump, auto-start)
// driven with random data, halts and back-pressure, checked against a word-list model.
module tb_run_dump_ctrl;

  localparam int DW = 16, AW = 16, RC = 8, MC = 10, RSTC = 2, RUNC = 50;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rstA, rstB, rstC;
  logic startReq, haltReq, dumpReady;
  int   sel;
  int   checks = 0;
  int   errors = 0;

  logic [DW-1:0] regFile [RC];
  logic [DW-1:0] memFile [16];

  run_dump_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .REG_COUNT(RC)) ifA ();
  run_dump_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .REG_COUNT(RC)) ifB ();
  run_dump_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .REG_COUNT(RC)) ifC ();

  assign ifA.start       = startReq && (sel == 0);
  assign ifA.halt_req    = haltReq;
  assign ifA.dump_ready  = dumpReady;
  assign ifA.reg_rd_data = regFile[ifA.reg_rd_addr];
  assign ifA.mem_rd_data = memFile[ifA.mem_rd_addr[3:0]];
  assign ifB.start       = startReq && (sel == 1);
  assign ifB.halt_req    = haltReq;
  assign ifB.dump_ready  = dumpReady;
  assign ifB.reg_rd_data = regFile[ifB.reg_rd_addr];
  assign ifB.mem_rd_data = memFile[ifB.mem_rd_addr[3:0]];
  assign ifC.start       = startReq && (sel == 2);
  assign ifC.halt_req    = haltReq;
  assign ifC.dump_ready  = dumpReady;
  assign ifC.reg_rd_data = regFile[ifC.reg_rd_addr];
  assign ifC.mem_rd_data = memFile[ifC.mem_rd_addr[3:0]];

  run_dump_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .REG_COUNT(RC), .MEM_DUMP_COUNT(MC),
                  .RESET_CYCLES(RSTC), .RUN_CYCLES(RUNC), .AUTO_START(1'b0))
    dutA (.clk(clk), .reset(rstA), .bus(ifA.master));
  run_dump_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .REG_COUNT(RC), .MEM_DUMP_COUNT(0),
                  .RESET_CYCLES(RSTC), .RUN_CYCLES(RUNC), .AUTO_START(1'b0))
    dutB (.clk(clk), .reset(rstB), .bus(ifB.master));
  run_dump_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .REG_COUNT(RC), .MEM_DUMP_COUNT(MC),
                  .RESET_CYCLES(RSTC), .RUN_CYCLES(RUNC), .AUTO_START(1'b1))
    dutC (.clk(clk), .reset(rstC), .bus(ifC.master));

  logic          sCoreReset, sCoreRun, sValid, sIsMem, sLast, sDone, sHalted;
  logic [2:0]    sRegAddr;
  logic [AW-1:0] sMemAddr;
  logic [DW-1:0] sData;
  logic [31:0]   sCycles;

  // Outputs of whichever instance the current test is exercising.
  always_comb begin
    sCoreReset = ifA.core_reset;  sCoreRun = ifA.core_run;   sValid  = ifA.dump_valid;
    sIsMem     = ifA.dump_is_mem; sLast    = ifA.dump_last;  sDone   = ifA.done;
    sHalted    = ifA.halted_early; sRegAddr = ifA.reg_rd_addr; sMemAddr = ifA.mem_rd_addr;
    sData      = ifA.dump_data;   sCycles  = ifA.cycle_count;
    if (sel == 1) begin
      sCoreReset = ifB.core_reset;  sCoreRun = ifB.core_run;   sValid  = ifB.dump_valid;
      sIsMem     = ifB.dump_is_mem; sLast    = ifB.dump_last;  sDone   = ifB.done;
      sHalted    = ifB.halted_early; sRegAddr = ifB.reg_rd_addr; sMemAddr = ifB.mem_rd_addr;
      sData      = ifB.dump_data;   sCycles  = ifB.cycle_count;
    end else if (sel == 2) begin
      sCoreReset = ifC.core_reset;  sCoreRun = ifC.core_run;   sValid  = ifC.dump_valid;
      sIsMem     = ifC.dump_is_mem; sLast    = ifC.dump_last;  sDone   = ifC.done;
      sHalted    = ifC.halted_early; sRegAddr = ifC.reg_rd_addr; sMemAddr = ifC.mem_rd_addr;
      sData      = ifC.dump_data;   sCycles  = ifC.cycle_count;
    end
  end

  typedef struct {
    logic          isMem;
    int            addr;
    logic [DW-1:0] data;
    logic          last;
  } word_t;

  task automatic randomizeData();
    for (int i = 0; i < RC; i++) regFile[i] = DW'($urandom);
    for (int i = 0; i < 16; i++) memFile[i] = DW'($urandom);
  endtask

  // Runs one complete start->DONE sequence on the selected instance. haltAt is the
  // RUN cycle (1-based) on which halt_req is raised; outside 1..RUNC means no halt.
  // readyMode: 0 = always ready, 1 = toggle each cycle, 2 = random.
  // abortMem >= 0 asserts instance C's reset while that memory word is presented.
  task automatic runScenario(input int haltAt, input int readyMode, input int memCount,
                             input bit autoMode, input int abortMem);
    word_t         expQ[$];
    word_t         w;
    int            expRun, resetSeen, runSeen, validSeen, wordIdx;
    bit            expHalt, finished, prevRun, sawValid, prevStall, addrOk;
    logic [DW-1:0] pData;
    logic [2:0]    pRegAddr;
    logic [AW-1:0] pMemAddr;
    logic          pIsMem;

    expHalt = (haltAt >= 1) && (haltAt <= RUNC);
    expRun  = expHalt ? haltAt : RUNC;
    for (int i = 0; i < RC; i++) begin
      w.isMem = 1'b0; w.addr = i; w.data = regFile[i];
      w.last  = (memCount == 0) && (i == RC - 1);
      expQ.push_back(w);
    end
    for (int i = 0; i < memCount; i++) begin
      w.isMem = 1'b1; w.addr = i; w.data = memFile[i]; w.last = (i == memCount - 1);
      expQ.push_back(w);
    end

    resetSeen = 0; runSeen = 0; validSeen = 0; wordIdx = 0;
    finished = 0; prevRun = 0; sawValid = 0; prevStall = 0;
    pData = '0; pRegAddr = '0; pMemAddr = '0; pIsMem = 1'b0;
    haltReq = 1'b0; dumpReady = 1'b1;
    if (!autoMode) startReq = 1'b1;

    for (int cyc = 0; cyc < 1000 && !finished; cyc++) begin
      @(posedge clk); #1;
      startReq = 1'b0;
      if (sCoreReset) resetSeen++;
      if (sCoreRun) runSeen++;
      if (prevStall) begin
        checks++;
        if (sValid !== 1'b1 || sData !== pData || sIsMem !== pIsMem ||
            sRegAddr !== pRegAddr || sMemAddr !== pMemAddr) begin
          errors++;
          $display("[TB] FAIL stall_stable word %0d: got valid %b data %h mem %b addr %0d/%0d, required valid 1 data %h mem %b addr %0d/%0d",
                   wordIdx, sValid, sData, sIsMem, sRegAddr, sMemAddr, pData, pIsMem, pRegAddr, pMemAddr);
        end
      end
      if (sValid && !sawValid) begin
        sawValid = 1;
        checks++;
        if (prevRun !== 1'b1) begin
          errors++;
          $display("[TB] FAIL dump_follows_run: cycle before first word had core_run %b, required 1", prevRun);
        end
      end
      if (sValid && abortMem >= 0 && sIsMem && sMemAddr == AW'(abortMem)) begin
        #2 rstC = 1'b0;
        #1;
        checks++;
        if ({sCoreReset, sCoreRun, sValid, sLast, sIsMem, sDone, sHalted} !== 7'b1000000 ||
            sCycles !== 32'd0 || sRegAddr !== 3'd0 || sMemAddr !== '0) begin
          errors++;
          $display("[TB] FAIL reset_mid_dump: got rst/run/valid/last/mem/done/halt %b%b%b%b%b%b%b cycles %0d addr %0d/%0d, required 1000000 cycles 0 addr 0/0",
                   sCoreReset, sCoreRun, sValid, sLast, sIsMem, sDone, sHalted, sCycles, sRegAddr, sMemAddr);
        end
        haltReq = 1'b0; dumpReady = 1'b1;
        return;
      end

      case (readyMode)
        0:       dumpReady = 1'b1;
        1:       dumpReady = ~dumpReady;
        default: dumpReady = 1'($urandom_range(0, 1));
      endcase
      if (sValid) begin
        validSeen++;
        if (dumpReady) begin
          checks++;
          if (wordIdx >= expQ.size()) begin
            errors++;
            $display("[TB] FAIL extra_word: word %0d accepted, required only %0d words", wordIdx, expQ.size());
          end else begin
            w = expQ[wordIdx];
            addrOk = w.isMem ? (sMemAddr == AW'(w.addr)) : (sRegAddr == 3'(w.addr));
            if (sIsMem !== w.isMem || sData !== w.data || sLast !== w.last || !addrOk) begin
              errors++;
              $display("[TB] FAIL word %0d: got mem %b data %h last %b addr %0d/%0d, required mem %b data %h last %b addr %0d",
                       wordIdx, sIsMem, sData, sLast, sRegAddr, sMemAddr, w.isMem, w.data, w.last, w.addr);
            end
          end
          wordIdx++;
        end
      end
      prevStall = sValid && !dumpReady;
      pData = sData; pRegAddr = sRegAddr; pMemAddr = sMemAddr; pIsMem = sIsMem;

      if (sCoreRun) haltReq = (runSeen == haltAt);
      else          haltReq = 1'($urandom_range(0, 1));
      if (sCoreRun || sValid) startReq = 1'($urandom_range(0, 1));
      prevRun = sCoreRun;
      if (sDone) finished = 1;
    end
    haltReq = 1'b0; startReq = 1'b0; dumpReady = 1'b1;

    checks++;
    if (!finished) begin
      errors++;
      $display("[TB] FAIL timeout: done never rose, words %0d run cycles %0d", wordIdx, runSeen);
      return;
    end
    checks++;
    if (resetSeen != RSTC) begin
      errors++;
      $display("[TB] FAIL core_reset_len: got %0d cycles, required %0d", resetSeen, RSTC);
    end
    checks++;
    if (runSeen != expRun) begin
      errors++;
      $display("[TB] FAIL core_run_len: got %0d cycles, required %0d", runSeen, expRun);
    end
    checks++;
    if (sCycles !== 32'(expRun)) begin
      errors++;
      $display("[TB] FAIL cycle_count: got %0d, required %0d", sCycles, expRun);
    end
    checks++;
    if (sHalted !== expHalt) begin
      errors++;
      $display("[TB] FAIL halted_early: got %b, required %b", sHalted, expHalt);
    end
    checks++;
    if (wordIdx != expQ.size()) begin
      errors++;
      $display("[TB] FAIL word_count: got %0d, required %0d", wordIdx, expQ.size());
    end
    checks++;
    if ({sCoreReset, sCoreRun, sValid} !== 3'b000) begin
      errors++;
      $display("[TB] FAIL done_outputs: got reset/run/valid %b%b%b, required 000", sCoreReset, sCoreRun, sValid);
    end
    if (readyMode == 0) begin
      checks++;
      if (validSeen != expQ.size()) begin
        errors++;
        $display("[TB] FAIL throughput: valid for %0d cycles, required %0d", validSeen, expQ.size());
      end
    end
  endtask

  task automatic test_reset();
    sel = 0;
    #1;
    checks++;
    if ({sCoreReset, sCoreRun, sValid, sLast, sIsMem, sDone, sHalted} !== 7'b1000000 ||
        sCycles !== 32'd0 || sRegAddr !== 3'd0 || sMemAddr !== '0) begin
      errors++;
      $display("[TB] FAIL reset_values: got rst/run/valid/last/mem/done/halt %b%b%b%b%b%b%b cycles %0d, required 1000000 cycles 0",
               sCoreReset, sCoreRun, sValid, sLast, sIsMem, sDone, sHalted, sCycles);
    end
    @(posedge clk); #1;
    rstA = 1'b1; rstB = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({sCoreReset, sCoreRun, sDone} !== 3'b100) begin
      errors++;
      $display("[TB] FAIL idle_no_autostart: got reset/run/done %b%b%b, required 100", sCoreReset, sCoreRun, sDone);
    end
  endtask

  task automatic test_full_run();
    sel = 0; randomizeData();
    runScenario(0, 0, MC, 1'b0, -1);
  endtask

  task automatic test_halt_early();
    sel = 0; randomizeData();
    runScenario(20, 0, MC, 1'b0, -1);
  endtask

  task automatic test_stall();
    sel = 0; randomizeData();
    runScenario(0, 1, MC, 1'b0, -1);
  endtask

  task automatic test_halt_last();
    sel = 0; randomizeData();
    runScenario(RUNC, 0, MC, 1'b0, -1);
  endtask

  task automatic test_back_to_back();
    sel = 0;
    for (int k = 0; k < 4; k++) begin
      randomizeData();
      runScenario(int'($urandom_range(0, 60)), 2, MC, 1'b0, -1);
    end
  endtask

  task automatic test_no_mem();
    sel = 1; randomizeData();
    runScenario(0, 0, 0, 1'b0, -1);
    randomizeData();
    runScenario(int'($urandom_range(1, 60)), 2, 0, 1'b0, -1);
  endtask

  task automatic test_auto_start();
    sel = 2; randomizeData();
    rstC = 1'b1;
    runScenario(25, 0, MC, 1'b1, 3);
    @(posedge clk); #1;
    rstC = 1'b1;
    randomizeData();
    runScenario(0, 2, MC, 1'b1, -1);
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if ({sDone, sCoreReset} !== 2'b10) begin
      errors++;
      $display("[TB] FAIL no_retrigger: got done/core_reset %b%b, required 10", sDone, sCoreReset);
    end
  endtask

  initial begin
    sel = 0; startReq = 1'b0; haltReq = 1'b0; dumpReady = 1'b1;
    randomizeData();
    rstA = 1'b1; rstB = 1'b1; rstC = 1'b1;
    #2;
    rstA = 1'b0; rstB = 1'b0; rstC = 1'b0;
    test_reset();
    test_full_run();
    test_halt_early();
    test_stall();
    test_halt_last();
    test_back_to_back();
    test_no_mem();
    test_auto_start();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/run_dump_ctrl.md
RUN_DUMP_CTRL -- requirements
Module: run_dump_ctrl

Interface
REQ-001 SHALL have parameters: DATA_WIDTH, default 16, dump word width; ADDR_WIDTH, default 16, memory address width; REG_COUNT, default 8, register words dumped; MEM_DUMP_COUNT, default 10, memory words dumped (0 permitted); RESET_CYCLES, default 2, core reset hold length (>=1); RUN_CYCLES, default 50, maximum run length (>=1); AUTO_START, default 0, 1 = start run on reset release.
REQ-002 SHALL have ports:
- clk  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-low; one clock, reset asynchronous active-low
- start  in  1  begin run, sampled in IDLE/DONE
- halt_req  in  1  core reached halt, sampled in RUN
- core_reset  out  1  active-high reset to core
- core_run  out  1  core clock enable
- reg_rd_addr  out  clog2(REG_COUNT)  register file read address
- reg_rd_data  in  DATA_WIDTH  combinational register read data
- mem_rd_addr  out  ADDR_WIDTH  data memory read address
- mem_rd_data  in  DATA_WIDTH  combinational memory read data
- dump_valid  out  1  dump word available
- dump_ready  in  1  consumer accepts word
- dump_data  out  DATA_WIDTH  dump word
- dump_is_mem  out  1  0 = register word, 1 = memory word
- dump_last  out  1  final word of dump
- cycle_count  out  32  RUN cycles elapsed
- done  out  1  run and dump complete
- halted_early  out  1  run ended by halt_req

Function
REQ-003 SHALL implement FSM IDLE, RESET_HOLD, RUN, DUMP_REG, DUMP_MEM, DONE.
REQ-004 IDLE -> RESET_HOLD on edge with start=1, or on first edge after reset release when AUTO_START=1.
REQ-005 RESET_HOLD SHALL last exactly RESET_CYCLES cycles, clear cycle_count, done, halted_early on entry, then -> RUN.
REQ-006 core_reset SHALL be 1 in IDLE and RESET_HOLD, 0 elsewhere; core_run SHALL be 1 only in RUN.
REQ-007 cycle_count SHALL increment by 1 on every RUN cycle, held in all other states except cleared per REQ-005.
REQ-008 RUN -> DUMP_REG after RUN_CYCLES cycles, or on edge with halt_req=1 (that cycle counted); halted_early set to 1 on halt exit.
REQ-009 halt_req on the final RUN cycle SHALL win: halted_early=1.
REQ-010 DUMP_REG: index i from 0 to REG_COUNT-1; reg_rd_addr=i; dump_data=reg_rd_data; dump_is_mem=0; dump_valid=1.
REQ-011 DUMP_MEM: index j from 0 to MEM_DUMP_COUNT-1; mem_rd_addr=j; dump_data=mem_rd_data; dump_is_mem=1; dump_valid=1.
REQ-012 Index SHALL advance only on edge with dump_valid & dump_ready; address and dump_data SHALL remain stable while dump_valid & !dump_ready.
REQ-013 After last register word accepted -> DUMP_MEM, or -> DONE if MEM_DUMP_COUNT=0; after last memory word accepted -> DONE.
REQ-014 dump_last SHALL be 1 only on overall final word (last memory word, or last register word when MEM_DUMP_COUNT=0).
REQ-015 dump_valid SHALL be 0 outside DUMP states; one word per cycle maximum throughput with dump_ready held 1.
REQ-016 DONE: done=1; start=1 -> RESET_HOLD (rerun); AUTO_START does not retrigger.
REQ-017 start SHALL be ignored in RESET_HOLD, RUN and DUMP states; halt_req ignored outside RUN.

Reset
REQ-018 reset low SHALL immediately force IDLE from any state, including mid-run and mid-dump, abandoning the dump.
REQ-019 Reset values: core_reset=1, core_run=0, dump_valid=0, dump_last=0, dump_is_mem=0, done=0, halted_early=0, cycle_count=0, reg_rd_addr=0, mem_rd_addr=0, indices=0.

Verification
REQ-020 Defaults, start pulse, halt_req=0, dump_ready=1 -> core_reset 1 for 2 cycles, core_run 1 for 50 cycles, 18 words (8 reg then 10 mem), dump_last on word 18, done=1, cycle_count=50, halted_early=0.
REQ-021 halt_req pulsed on 20th RUN cycle -> cycle_count=20, halted_early=1, dump follows immediately.
REQ-022 dump_ready toggled 1/0 every cycle -> each word presented until accepted, dump_data/addresses stable while stalled, 18 words in order, none duplicated.
REQ-023 MEM_DUMP_COUNT=0 -> 8 register words only, dump_last on reg word 7, then DONE.
REQ-024 reset asserted during DUMP_MEM word 3 -> outputs at reset values same cycle; AUTO_START=1 reset release -> RESET_HOLD on next edge, full run repeats.
REQ-025 halt_req on 50th RUN cycle -> halted_early=1, cycle_count=50.
